view_req_arbiter: RTL and testbench

//  Shares the single VIEW command/callback channel between NUM_REQ game controllers
//  (pregame, ingame, postgame, score). Each controller asserts a level request with a

---
 rtl/view_req_arbiter_pkg.sv | 38 +++
 rtl/view_req_arbiter_rr_picker.sv | 41 ++++
 rtl/view_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_view_req_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/view_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// view_req_arbiter_pkg
//   Shared definitions for the controller-to-VIEW arbitration layer:
//   frame timing, arbiter state encoding, the VIEW command codes used by the
//   game controllers, and a small round-robin helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package view_req_arbiter_pkg;

    // One video frame expressed in system clocks; default VIEW wait limit.
    localparam int FRAME_CLOCK = 833_333;

    // Arbiter FSM encoding. The values are fixed so that debug tools and the
    // sound-channel arbiter can decode the state the same way.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } arb_state_e;

    // VIEW command codes shared by the pregame/ingame/postgame/score controllers.
    localparam int VIEW_CMD_W = 8;
    typedef enum logic [VIEW_CMD_W-1:0] {
        VCMD_NOP         = 8'h00,
        VCMD_SHOW_TITLE  = 8'h01,
        VCMD_SHOW_LEVEL  = 8'h02,
        VCMD_DRAW_FRAME  = 8'h10,
        VCMD_SHOW_RESULT = 8'h20,
        VCMD_SHOW_SCORE  = 8'h30
    } view_cmd_e;

    // Next round-robin index after idx, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/view_req_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. Searches req_i starting at ptr_i and
//   moving upward (mod NUM_REQ); reports the first set bit.
//   Ports:
//     req_i     in   NUM_REQ   request vector
//     ptr_i     in   IDX_W     index with highest priority this round
//     any_o     out  1         at least one request is set
//     winner_o  out  IDX_W     selected index (0 when any_o is low)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic                       any_o,
    output logic [$clog2(NUM_REQ)-1:0] winner_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] idx;

    // Walk the candidates from lowest to highest priority so the last hit,
    // the one nearest ptr_i, overwrites the others.
    always_comb begin
        // NOTE: every always_comb output gets a default before any condition,
        // otherwise synthesis infers a latch to hold the old value.
        winner_o = '0;
        idx      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (req_i[idx]) begin
                winner_o = idx;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/view_req_arbiter.sv
// -----------------------------------------------------------------------------
// view_req_arbiter
//   Shares the single VIEW command/callback channel between NUM_REQ game
//   controllers. Round-robin grant, one command strobe to VIEW, then wait for
//   cbk_from_view or TIMEOUT clocks, then a done pulse back to the winner.
//   All outputs are registered.
//   Ports:
//     clock          in   1               system clock, rising edge
//     reset          in   1               asynchronous, active-high
//     req            in   NUM_REQ         level request per controller
//     cmd_flat       in   NUM_REQ*CMD_W   command of requester i at [i*CMD_W +: CMD_W]
//     done           out  NUM_REQ         one-cycle completion pulse to the winner
//     timeout        out  NUM_REQ         coincident with done when VIEW timed out
//     view_cmd       out  CMD_W           command latched at grant
//     view_valid     out  1               one-cycle command strobe to VIEW
//     cbk_from_view  in   1               VIEW completion, honoured only in S_WAIT
//     busy           out  1               high whenever the FSM is not idle
//     grant_id       out  IDX_W           current or last winner
// -----------------------------------------------------------------------------
module view_req_arbiter
    import view_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CMD_W   = 8,
    parameter int TIMEOUT = FRAME_CLOCK,
    parameter int TMO_W   = 20
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CMD_W-1:0]   cmd_flat,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         timeout,
    output logic [CMD_W-1:0]           view_cmd,
    output logic                       view_valid,
    input  logic                       cbk_from_view,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [IDX_W-1:0]   grant_id_q;
    logic [CMD_W-1:0]   view_cmd_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] timeout_q;
    logic               view_valid_q;
    logic               busy_q;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic [CMD_W-1:0]   cmd_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant_oh;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cmd_unpack
        assign cmd_arr[g] = cmd_flat[g*CMD_W +: CMD_W];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .any_o    (pick_any),
        .winner_o (pick_idx)
    );

    assign grant_oh = NUM_REQ'(1) << grant_id_q;
    assign ptr_d    = IDX_W'(rr_next(int'(grant_id_q), NUM_REQ));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            grant_id_q   <= '0;
            view_cmd_q   <= '0;
            tmo_cnt_q    <= '0;
            done_q       <= '0;
            timeout_q    <= '0;
            view_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; the pulse
            // registers are cleared here and a later assignment in the same
            // cycle wins, which yields exactly one-cycle pulses.
            done_q       <= '0;
            timeout_q    <= '0;
            view_valid_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (pick_any) begin
                        grant_id_q   <= pick_idx;
                        view_cmd_q   <= cmd_arr[pick_idx];
                        view_valid_q <= 1'b1;   // visible during S_ISSUE
                        busy_q       <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt_q <= '0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    // The callback takes precedence over an expiring timer.
                    if (cbk_from_view) begin
                        done_q  <= grant_oh;
                        state_q <= S_DONE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        done_q    <= grant_oh;
                        timeout_q <= grant_oh;
                        state_q   <= S_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                S_DONE: begin
                    ptr_q   <= ptr_d;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done       = done_q;
    assign timeout    = timeout_q;
    assign view_cmd   = view_cmd_q;
    assign view_valid = view_valid_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_view_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_view_req_arbiter
//   Self-checking bench for view_req_arbiter with TIMEOUT shortened to 16.
//   Expected behaviour comes from a transaction-level model: the round-robin
//   rule applied to a pointer, plus the cycle offsets of strobe, callback and
//   done measured from the grant.
// -----------------------------------------------------------------------------
module tb_view_req_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 8;
    localparam int TMO  = 16;
    localparam int TW   = 5;

    logic              clock;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*CW-1:0] cmd_flat;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   timeout;
    logic [CW-1:0]     view_cmd;
    logic              view_valid;
    logic              cbk_from_view;
    logic              busy;
    logic [1:0]        grant_id;

    int n_cmp = 0;
    int n_bad = 0;
    int ptr_m = 0;   // model of the round-robin pointer

    view_req_arbiter #(
        .NUM_REQ (NREQ),
        .CMD_W   (CW),
        .TIMEOUT (TMO),
        .TMO_W   (TW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .cmd_flat      (cmd_flat),
        .done          (done),
        .timeout       (timeout),
        .view_cmd      (view_cmd),
        .view_valid    (view_valid),
        .cbk_from_view (cbk_from_view),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    // Advance one cycle; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // First requester at or after p (mod NREQ); -1 when nothing requests.
    function automatic int model_pick(input int p, input logic [NREQ-1:0] r);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        req = '0;
        cbk_from_view = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        ptr_m = 0;
        tick();
    endtask

    // One full transaction starting from an observed idle cycle.
    // Cycle n is the n-th cycle after req is applied: n=1 strobe, n=2 first
    // wait cycle. cbk_cyc=0 means VIEW never answers.
    task automatic run_txn(input string tag, input logic [NREQ-1:0] r,
                           input int cbk_cyc, input bit drop, input bit scramble,
                           input bit stale, output int got_w);
        int            exp_w;
        int            done_cyc;
        bit            tmo;
        logic [CW-1:0] exp_cmd;
        logic [NREQ-1:0] oh;
        logic [NREQ-1:0] exp_done;
        logic [NREQ-1:0] exp_tmo;
        req      = r;
        exp_w    = model_pick(ptr_m, r);
        exp_cmd  = cmd_flat[exp_w*CW +: CW];
        oh       = NREQ'(1) << exp_w;
        tmo      = (cbk_cyc == 0);
        done_cyc = tmo ? TMO + 2 : cbk_cyc + 1;
        got_w    = -1;
        for (int n = 1; n <= done_cyc; n++) begin
            tick();
            if (n == 1) got_w = int'(grant_id);
            exp_done = (n == done_cyc) ? oh : '0;
            exp_tmo  = (n == done_cyc && tmo) ? oh : '0;
            n_cmp++;
            if (view_valid !== (n == 1)) begin
                n_bad++;
                $display("FAIL %s.view_valid cyc %0d: got %b want %b", tag, n, view_valid, (n == 1));
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s.busy cyc %0d: got %b want 1", tag, n, busy);
            end
            n_cmp++;
            if (int'(grant_id) !== exp_w) begin
                n_bad++;
                $display("FAIL %s.grant_id cyc %0d: got %0d want %0d", tag, n, grant_id, exp_w);
            end
            n_cmp++;
            if (view_cmd !== exp_cmd) begin
                n_bad++;
                $display("FAIL %s.view_cmd cyc %0d: got %h want %h", tag, n, view_cmd, exp_cmd);
            end
            n_cmp++;
            if (done !== exp_done) begin
                n_bad++;
                $display("FAIL %s.done cyc %0d: got %b want %b", tag, n, done, exp_done);
            end
            n_cmp++;
            if (timeout !== exp_tmo) begin
                n_bad++;
                $display("FAIL %s.timeout cyc %0d: got %b want %b", tag, n, timeout, exp_tmo);
            end
            // Drive inputs for the cycle that follows.
            cbk_from_view = (n == cbk_cyc) || (stale && (n == 1 || n == done_cyc));
            if (drop && n == 2) req = req & ~oh;
            if (scramble) cmd_flat = NREQ*CW'($urandom);
            if (n == done_cyc) req = req & ~oh;
        end
        ptr_m = (exp_w + 1) % NREQ;
        tick();
        cbk_from_view = 1'b0;
        n_cmp++;
        if ({busy, view_valid, done, timeout} !== '0) begin
            n_bad++;
            $display("FAIL %s.after_done: got busy=%b vv=%b done=%b tmo=%b want all 0",
                     tag, busy, view_valid, done, timeout);
        end
        n_cmp++;
        if (int'(grant_id) !== exp_w || view_cmd !== exp_cmd) begin
            n_bad++;
            $display("FAIL %s.hold_after_done: got id=%0d cmd=%h want id=%0d cmd=%h",
                     tag, grant_id, view_cmd, exp_w, exp_cmd);
        end
    endtask

    // A callback pulse while idle with no requests must change nothing.
    task automatic idle_cbk_probe(input string tag);
        req = '0;
        cbk_from_view = 1'b1;
        tick();
        cbk_from_view = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({busy, view_valid, done, timeout} !== '0) begin
                n_bad++;
                $display("FAIL %s.idle_cbk cyc %0d: got busy=%b vv=%b done=%b tmo=%b want all 0",
                         tag, k, busy, view_valid, done, timeout);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int w;
        #1;
        n_cmp++;
        if ({done, timeout, view_valid, busy, grant_id, view_cmd} !== '0) begin
            n_bad++;
            $display("FAIL reset_init: got done=%b tmo=%b vv=%b busy=%b id=%0d cmd=%h want all 0",
                     done, timeout, view_valid, busy, grant_id, view_cmd);
        end
        repeat (2) tick();
        reset = 1'b0;
        ptr_m = 0;
        tick();
        cmd_flat = 32'h3C_A5_5A_C3;
        run_txn("pre_reset", 4'b0100, 4, 0, 0, 0, w);   // leaves pointer at 3
        // Start a transaction for requester 0 and reset it while waiting.
        req = 4'b0001;
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid.busy_before: got %b want 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({done, timeout, view_valid, busy, grant_id, view_cmd} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid.async: got done=%b tmo=%b vv=%b busy=%b id=%0d cmd=%h want all 0",
                     done, timeout, view_valid, busy, grant_id, view_cmd);
        end
        req = '0;
        tick();
        reset = 1'b0;
        ptr_m = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (done !== '0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_mid.no_done cyc %0d: got done=%b busy=%b want 0/0", k, done, busy);
            end
        end
        run_txn("post_reset", 4'b1111, 3, 0, 0, 0, w);
        n_cmp++;
        if (w !== 0) begin
            n_bad++;
            $display("FAIL reset_mid.restart_ptr: got winner %0d want 0", w);
        end
    endtask

    task automatic test_single_cmd();
        int w;
        cmd_flat = 32'h11_A5_22_33;   // requester 2 carries 8'hA5
        run_txn("single_cmd", 4'b0100, 4, 0, 0, 0, w);
    endtask

    task automatic test_rotation();
        int w;
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        cmd_flat = NREQ*CW'($urandom);
        for (int k = 0; k < 5; k++) begin
            run_txn("rotation", 4'b1111, 3, 0, 0, 0, w);
            n_cmp++;
            if (w !== exp_seq[k]) begin
                n_bad++;
                $display("FAIL rotation.order step %0d: got %0d want %0d", k, w, exp_seq[k]);
            end
        end
    endtask

    task automatic test_timeout();
        int w;
        cmd_flat = NREQ*CW'($urandom);
        run_txn("timeout", 4'b0010, 0, 0, 0, 0, w);
        idle_cbk_probe("timeout_late_cbk");
    endtask

    task automatic test_cbk_at_limit();
        int w;
        cmd_flat = NREQ*CW'($urandom);
        run_txn("cbk_at_limit", 4'b1000, TMO + 1, 0, 0, 0, w);
        idle_cbk_probe("cbk_in_idle");
    endtask

    task automatic test_drop_and_cmd_change();
        int w;
        cmd_flat = NREQ*CW'($urandom);
        run_txn("drop_cmd", 4'b0110, 5, 1, 1, 1, w);
    endtask

    task automatic test_random();
        int w;
        int cbk;
        logic [NREQ-1:0] r;
        for (int k = 0; k < 24; k++) begin
            r = NREQ'($urandom_range(1, 15));
            cmd_flat = NREQ*CW'($urandom);
            cbk = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, TMO + 1));
            run_txn("random", r, cbk, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
        end
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        cmd_flat = '0;
        cbk_from_view = 1'b0;
        test_reset();
        test_single_cmd();
        test_rotation();
        test_timeout();
        test_cbk_at_limit();
        test_drop_and_cmd_change();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
